// File: rtl/bus_arbiter4.sv
// bus_arbiter4 - round-robin owner selection for a shared 4-source tri-state bus.
//
// The arbiter turns four level requests into a registered one-hot grant plus
// the select/enable pair for the bus decoder that drives the four bufif1
// drivers. One all-off turnaround cycle separates consecutive owners, and an
// optional hold timeout bounds how long a single owner keeps the bus.
//
// Handshake: req[i] is a level request. Master i holds it high for as long as it
// wants the bus. The master owns the bus exactly while gnt[i] is high. Dropping
// req[i] while granted hands the bus back on the next edge. There is no
// separate done strobe.
//
// Parameters
//   CNT_W     width of the tenure counter
//   MAX_HOLD  longest grant in cycles (0 = no timeout), 0 .. 2^CNT_W-1
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   arbiter enable; 0 blocks new grants only
//   req[3:0]   in   level requests
//   gnt[3:0]   out  registered one-hot grant, 0 when the bus is unowned
//   sel[1:0]   out  index of the current or last owner (decoder select)
//   bus_en     out  decoder enable, equals |gnt
//   busy       out  high while in GRANT
//   timeout    out  one-cycle pulse when MAX_HOLD revokes a grant
//   dbg_state  out  FSM state: 0 = IDLE, 1 = GRANT, 2 = TURN
module bus_arbiter4 #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       bus_en,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  // Count value on which the last cycle of a full-length tenure is sampled.
  localparam logic             LP_TO_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_sel;
  logic             r_bus_en;
  logic             r_busy;
  logic             r_timeout;

  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_win;
  logic             w_any;
  logic             w_own_req;
  logic             w_cnt_hit;
  logic             w_release;

  // Rotate the requests so that bit 0 is the current highest-priority index.
  // The lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    w_rot = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_rot[k] = req[2'(r_ptr + 2'(k))];
    end
  end

  // Scan from the top down so the lowest set offset is the one left in w_off.
  always_comb begin
    w_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = 2'(k);
      end
    end
  end

  assign w_win     = r_ptr + w_off;
  assign w_any     = |req;
  assign w_own_req = req[r_sel];
  assign w_cnt_hit = LP_TO_EN && (r_cnt == LP_LAST);
  assign w_release = !w_own_req || w_cnt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_cnt     <= '0;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_bus_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        // IDLE and TURN arbitrate identically. The only difference is that
        // TURN never lingers: without a grant it falls back to IDLE.
        S_IDLE, S_TURN: begin
          if (en && w_any) begin
            r_gnt    <= 4'b0001 << w_win;
            r_sel    <= w_win;
            r_bus_en <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_GRANT;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        // en and other masters' requests are ignored here. The tenure ends
        // only on the owner's drop or on the hold limit.
        S_GRANT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_release) begin
            r_gnt     <= 4'b0000;
            r_bus_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_ptr     <= r_sel + 2'd1;
            // A simultaneous voluntary drop counts as voluntary, not a timeout.
            r_timeout <= w_cnt_hit && w_own_req;
            r_state   <= S_TURN;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign bus_en    = r_bus_en;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4 - bench for bus_arbiter4.
//
// Three instances share the same stimulus and differ only in MAX_HOLD
// (3, 0 and 16). A behavioural model tracks owner, priority pointer and tenure
// length for each instance. It pushes the expected outputs into exp_q on every
// rising edge. Those values are popped and compared on the following falling edge.
module tb_bus_arbiter4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;

  logic [3:0] gnt_w [3];
  logic [1:0] sel_w [3];
  logic       be_w  [3];
  logic       busy_w[3];
  logic       to_w  [3];
  logic [1:0] st_w  [3];

  int n_checks;
  int n_errors;

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_arbiter4 #(
      .CNT_W   (8),
      .MAX_HOLD((g == 0) ? 3 : ((g == 1) ? 0 : 16))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .req      (req),
      .gnt      (gnt_w[g]),
      .sel      (sel_w[g]),
      .bus_en   (be_w[g]),
      .busy     (busy_w[g]),
      .timeout  (to_w[g]),
      .dbg_state(st_w[g])
    );
  end

  // ---------------------------------------------------------------- model
  // Expected vector layout: [10:9] state, [8] timeout, [7] busy, [6] bus_en,
  // [5:4] sel, [3:0] gnt.
  logic [10:0] exp_q[$];

  int m_owner[3];   // current owner index, -1 when nobody owns the bus
  int m_ptr  [3];   // index with highest priority
  int m_held [3];   // grant cycles already completed by the owner
  int m_sel  [3];
  bit m_turn [3];
  bit m_to   [3];

  function automatic int hold_of(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 0 : 16);
  endfunction

  task automatic model_step(input int g);
    int          h;
    int          held;
    int          w;
    bit          still;
    bit          expired;
    logic [1:0]  st;
    logic [10:0] e;
    h       = hold_of(g);
    m_to[g] = 1'b0;
    if (rst) begin
      m_owner[g] = -1;
      m_ptr[g]   = 0;
      m_sel[g]   = 0;
      m_held[g]  = 0;
      m_turn[g]  = 1'b0;
    end else if (m_owner[g] >= 0) begin
      held    = m_held[g] + 1;
      still   = req[m_owner[g]];
      expired = (h != 0) && (held == h);
      if (!still || expired) begin
        m_to[g]    = still && expired;
        m_ptr[g]   = (m_owner[g] + 1) % 4;
        m_owner[g] = -1;
        m_turn[g]  = 1'b1;
      end else begin
        m_held[g] = held;
      end
    end else begin
      m_turn[g] = 1'b0;
      if (en && (req != 4'b0000)) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          if (w < 0 && req[(m_ptr[g] + k) % 4]) w = (m_ptr[g] + k) % 4;
        end
        m_owner[g] = w;
        m_sel[g]   = w;
        m_held[g]  = 0;
      end
    end
    st = (m_owner[g] >= 0) ? 2'd1 : (m_turn[g] ? 2'd2 : 2'd0);
    e[10:9] = st;
    e[8]    = m_to[g];
    e[7]    = (m_owner[g] >= 0);
    e[6]    = (m_owner[g] >= 0);
    e[5:4]  = 2'(m_sel[g]);
    e[3:0]  = (m_owner[g] >= 0) ? 4'(1 << m_owner[g]) : 4'b0000;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) model_step(g);
  end

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [10:0] e;
    for (int g = 0; g < 3; g++) begin
      if (exp_q.size() == 0) begin
        check("model_q_underflow", 32'(0), 32'(1));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("gnt[%0d]", g),     32'(gnt_w[g]),  32'(e[3:0]));
        check($sformatf("sel[%0d]", g),     32'(sel_w[g]),  32'(e[5:4]));
        check($sformatf("bus_en[%0d]", g),  32'(be_w[g]),   32'(e[6]));
        check($sformatf("busy[%0d]", g),    32'(busy_w[g]), 32'(e[7]));
        check($sformatf("timeout[%0d]", g), 32'(to_w[g]),   32'(e[8]));
        check($sformatf("state[%0d]", g),   32'(st_w[g]),   32'(e[10:9]));
      end
    end
  endtask

  // Directed-test bookkeeping: timeout pulses per instance and the sequence of
  // fresh grants seen on instance 0.
  int         to_cnt[3];
  logic [3:0] seen0_q[$];
  logic       prev_be0;

  task automatic clear_tracking();
    for (int g = 0; g < 3; g++) to_cnt[g] = 0;
    seen0_q.delete();
    prev_be0 = 1'b0;
  endtask

  task automatic track();
    for (int g = 0; g < 3; g++) if (to_w[g] === 1'b1) to_cnt[g]++;
    if (be_w[0] === 1'b1 && !prev_be0) seen0_q.push_back(gnt_w[0]);
    prev_be0 = (be_w[0] === 1'b1);
  endtask

  // ---------------------------------------------------------------- driver
  task automatic tick(input logic r, input logic e, input logic [3:0] q);
    rst = r;
    en  = e;
    req = q;
    @(negedge clk);
    compare_all();
    track();
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [3:0] rr_exp[5];
  logic [3:0] rq;
  int         n_hi;
  int         flip_max;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0000;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    clear_tracking();

    // Reset with every request high, then first grant one cycle after release.
    tick(1'b1, 1'b1, 4'b1111);
    tick(1'b1, 1'b1, 4'b1111);
    check("rst_gnt", 32'(gnt_w[0]), 32'(4'b0000));
    check("rst_sel", 32'(sel_w[0]), 32'(2'd0));
    check("rst_timeout", 32'(to_w[0]), 32'(1'b0));
    clear_tracking();
    tick(1'b0, 1'b1, 4'b1111);
    check("rst_first_gnt", 32'(gnt_w[0]), 32'(4'b0001));

    // Round robin on the MAX_HOLD=3 instance: 3 on, 1 off per owner.
    for (int i = 0; i < 18; i++) tick(1'b0, 1'b1, 4'b1111);
    check("rr_count", 32'(seen0_q.size()), 32'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < seen0_q.size()) check($sformatf("rr_order%0d", i), 32'(seen0_q[i]), 32'(rr_exp[i]));
    end
    check("rr_timeouts", 32'(to_cnt[0]), 32'(4));

    // Voluntary release on the MAX_HOLD=16 instance.
    tick(1'b1, 1'b1, 4'b0000);
    clear_tracking();
    n_hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 4'b0100);
      if (gnt_w[2] === 4'b0100) n_hi++;
    end
    tick(1'b0, 1'b1, 4'b0000);
    if (gnt_w[2] === 4'b0100) n_hi++;
    check("vol_len", 32'(n_hi), 32'(5));
    check("vol_turn", 32'(st_w[2]), 32'(2'd2));
    check("vol_sel_kept", 32'(sel_w[2]), 32'(2'd2));
    tick(1'b0, 1'b1, 4'b0000);
    check("vol_idle", 32'(st_w[2]), 32'(2'd0));
    check("vol_no_timeout", 32'(to_cnt[2]), 32'(0));

    // Fairness: owner 3 leaves while master 0 waits -> master 0 is next.
    tick(1'b1, 1'b1, 4'b0000);
    clear_tracking();
    tick(1'b0, 1'b1, 4'b1000);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 4'b1001);
    check("fair_count", 32'(seen0_q.size()), 32'(2));
    if (seen0_q.size() >= 2) begin
      check("fair_first", 32'(seen0_q[0]), 32'(4'b1000));
      check("fair_next", 32'(seen0_q[1]), 32'(4'b0001));
    end
    tick(1'b0, 1'b1, 4'b0001);
    tick(1'b0, 1'b1, 4'b0001);
    check("fair_vol_next", 32'(gnt_w[2]), 32'(4'b0001));

    // Enable blocks new grants only.
    tick(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b0010);
    check("en_block", 32'(gnt_w[2]), 32'(4'b0000));
    tick(1'b0, 1'b1, 4'b0010);
    check("en_grant", 32'(gnt_w[2]), 32'(4'b0010));
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 4'b0010);
    check("en_hold", 32'(gnt_w[2]), 32'(4'b0010));
    tick(1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b0010);
    check("en_no_regrant", 32'(gnt_w[2]), 32'(4'b0000));

    // Reset in the middle of a grant.
    tick(1'b0, 1'b1, 4'b0100);
    tick(1'b0, 1'b1, 4'b0100);
    tick(1'b1, 1'b1, 4'b0100);
    check("rst_mid_gnt", 32'(gnt_w[1]), 32'(4'b0000));
    check("rst_mid_be", 32'(be_w[1]), 32'(1'b0));

    // MAX_HOLD=0: a held request keeps the bus indefinitely.
    clear_tracking();
    n_hi = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b1, 4'b0100);
      if (gnt_w[1] === 4'b0100) n_hi++;
    end
    check("nohold_len", 32'(n_hi), 32'(300));
    check("nohold_timeouts", 32'(to_cnt[1]), 32'(0));

    // Randomized traffic: fast-changing requests, then slow-changing ones so
    // long tenures reach the 16-cycle limit.
    tick(1'b1, 1'b1, 4'b0000);
    rq = 4'b0000;
    for (int phase = 0; phase < 2; phase++) begin
      flip_max = (phase == 0) ? 3 : 40;
      for (int i = 0; i < 2000; i++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, flip_max) == 0) rq[b] = ~rq[b];
        end
        tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), rq);
      end
    end

    check("model_q_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
- Round-robin arbiter sharing one 4-source tri-state bus (2-bit select + enable decoder driving four bufif1 drivers) among four requesters.
- Converts level requests into a registered one-hot grant and the matching select/enable for the bus decoder.
- Inserts one all-off turnaround cycle between owners so two drivers never contend on the bus.
- Bounds bus tenure with an optional hold timeout.

Parameters:
- CNT_W, 8, width of the tenure counter.
- MAX_HOLD, 16, maximum grant length in cycles. 0 disables the timeout. Legal range is 0 to 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable. 0 blocks new grants only.
- req  input  4  level requests. req[i] is held high for as long as master i wants the bus.
- gnt  output  4  registered one-hot grant; 0 when nobody owns the bus.
- sel  output  2  {s1,s0} index of the current or last owner, for the bus decoder.
- bus_en  output  1  decoder enable. Equals |gnt.
- busy  output  1  high in GRANT state.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst=1 at a clk edge): gnt=0, sel=0, bus_en=0, busy=0, timeout=0, state=IDLE, ptr=0, cnt=0. Reset wins over every other event and aborts any grant on the same edge.
- ptr is the index that currently has highest priority. Winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
- All outputs are registered; there is no combinational path from req to gnt.
- State IDLE:
  - If en=1 and req!=0: the next edge loads gnt=onehot(winner), sel=winner, bus_en=1, cnt=0, state=GRANT.
  - Otherwise stay in IDLE.
  - Latency is exactly 1 cycle from req being sampled high to gnt high.
- State GRANT:
  - cnt increments by 1 each cycle.
  - Release condition: req[sel]=0 sampled, or (MAX_HOLD!=0 and cnt==MAX_HOLD-1).
  - On release, the next edge sets gnt=0, bus_en=0, ptr=(sel+1) mod 4, state=TURN. sel keeps the old owner.
  - timeout=1 for that one cycle only if release was caused by the count while req[sel] was still 1. If both causes hit together, timeout=0.
  - en is ignored in GRANT. A current grant always completes.
  - Other requesters' req changes have no effect during GRANT.
- State TURN:
  - Always exactly one cycle with gnt=0 and bus_en=0.
  - Arbitrates as IDLE does, using the updated ptr: with en=1 and req!=0 the next edge grants (state=GRANT); otherwise it goes to IDLE.
  - Minimum dead time between two owners is therefore exactly 1 cycle.
- An owner that timed out but keeps req high is re-granted only after the other active requesters have had their turn. If it is the sole requester, it is re-granted after the TURN cycle.
- A master that drops req then re-raises it in the same GRANT tenure is not re-granted within that tenure: release happens on the drop.
- Invariants: gnt is always one-hot or zero; bus_en==|gnt; busy==bus_en; sel==index of gnt whenever bus_en=1.

Test Plan:
- Reset: after rst=1 for 2 cycles with req=4'b1111 -> gnt=0, bus_en=0, sel=0, timeout=0. On the first edge with rst=0 and en=1 -> gnt=4'b0001 one cycle later.
- Round robin: req=4'b1111 held, MAX_HOLD=3 -> grants 0001,0010,0100,1000,0001. Each lasts 3 cycles with a timeout pulse, separated by exactly 1 cycle of gnt=0.
- Voluntary release: req=4'b0100 for 5 cycles then 0 -> gnt=0100, sel=2'b10 for 5 cycles, then gnt=0. timeout stays 0. State passes TURN then IDLE.
- Fairness after release: owner 3 releases while req=4'b1001 -> next grant 0001, not 1000.
- Enable: en=0 with req=4'b0010 -> gnt stays 0. Dropping en mid-GRANT keeps gnt until req[1] falls; there is no regrant while en=0.
- Reset mid-grant and MAX_HOLD=0: rst asserted during a GRANT -> gnt=0 at the next edge. With MAX_HOLD=0 and req[2] held for 300 cycles -> gnt=0100 continuously and timeout never pulses.
